// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a start/done handshake.
// One ripple_carry_adder does all the arithmetic, one partial product per CALC cycle.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       carry_out
);
  logic c;

  always_comb begin
    s = '0;
    c = c_in;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carry_out = c;
  end
endmodule

// Handshake: start is honoured only in IDLE (no queueing). done is a one-cycle
// pulse marking product valid; product then holds until the next accepted start.
module shift_add_multiplier #(
  parameter int WIDTH = 4  // tied to the 4-bit ripple_carry_adder; no other value is legal
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [1:0]       cnt;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  assign add_b = acc_lo[0] ? mcand : '0;

  ripple_carry_adder u_adder (
    .a         (acc_hi),
    .b         (add_b),
    .c_in      (1'b0),
    .s         (sum),
    .carry_out (carry_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_state = state;

  // carry_out becomes the new top bit of the accumulator, so a 5-bit partial sum is never truncated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc_hi <= {carry_out, sum[WIDTH-1:1]};
      acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      cnt    <= cnt + 2'd1;
      if (cnt == 2'd3)
        product <= {carry_out, sum[WIDTH-1:1], sum[0], acc_lo[WIDTH-1:1]};
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: vector table, multi-cycle corner
// sequences and an exhaustive 16x16 sweep, checked against an expected queue.

module tb_shift_add_multiplier;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one operation starting at the next falling edge and waits for done.
  // Operands are scrambled right after capture to prove they are latched.
  task automatic do_mul(input logic [3:0] x, input logic [3:0] y, input string tag);
    int k;
    int busy_cnt;
    bit got;
    logic [7:0] e;
    exp_q.push_back({4'b0, x} * {4'b0, y});
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom_range(15));
    b = 4'($urandom_range(15));
    k = 1; busy_cnt = 0; got = 0;
    while (k <= 20 && !got) begin
      if (busy) busy_cnt++;
      if (done) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      check({tag, " done timeout"}, 0, 1);
    end else begin
      check({tag, " latency"}, k, 5);
      check({tag, " busy cycles"}, busy_cnt, 4);
      check({tag, " product"}, product, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    vecs[0] = '{4'd0,  4'd0,  8'h00};
    vecs[1] = '{4'd15, 4'd15, 8'hE1};
    vecs[2] = '{4'd3,  4'd5,  8'h0F};
    vecs[3] = '{4'd9,  4'd7,  8'h3F};
    vecs[4] = '{4'd1,  4'd15, 8'h0F};
    vecs[5] = '{4'd15, 4'd1,  8'h0F};
    vecs[6] = '{4'd8,  4'd8,  8'h40};
    vecs[7] = '{4'd12, 4'd10, 8'h78};
    vecs[8] = '{4'd0,  4'd15, 8'h00};
    vecs[9] = '{4'd7,  4'd11, 8'h4D};

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 0);
    check("reset state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back at the earliest legal start.
    for (int i = 0; i < 10; i++) begin
      do_mul(vecs[i].a, vecs[i].b, "vec");
      check("vec table product", product, vecs[i].exp);
    end

    // Product holds and done stays low after the pulse.
    repeat (2) begin
      @(negedge clk);
      check("hold done low", done, 0);
      check("hold product", product, 8'h4D);
    end

    // start held through CALC/DONE with operands changing: one result only.
    begin
      int done_pulses;
      done_pulses = 0;
      @(negedge clk);
      a = 4'd6; b = 4'd7; start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        a = 4'd15; b = 4'd15;
        if (done) done_pulses++;
      end
      start = 1'b0;
      check("held start product", product, 8'd42);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done) done_pulses++;
      end
      check("held start done pulses", done_pulses, 1);
      check("held start product stable", product, 8'd42);
    end

    // Reset on the second CALC cycle aborts immediately and issues no done.
    begin
      int done_pulses;
      done_pulses = 0;
      @(negedge clk);
      a = 4'd13; b = 4'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort first calc busy", busy, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort product", product, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done) done_pulses++;
      end
      check("abort no done", done_pulses, 0);
      do_mul(4'd13, 4'd11, "after abort");
      check("after abort value", product, 8'd143);
    end

    // Exhaustive sweep.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_mul(4'(i), 4'(j), "sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
